// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes and multiply/divide engine states
package alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MFHI  = 4'b1101;
  localparam logic [3:0] ALU_MFLO  = 4'b1110;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operand/opcode/result bundle between control and the ALU
interface alu_muldiv_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [3:0] ALUop;
  logic start;
  logic [WIDTH-1:0] result;
  logic zero;
  logic overflow;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output opA, opB, ALUop, start, input result, zero, overflow, busy, done, hi, lo);
  modport slave (input opA, opB, ALUop, start, output result, zero, overflow, busy, done, hi, lo);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned shift-add multiply / restoring divide with HI/LO
module muldiv_seq import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] m, ph, pl, nh, nl;
  logic [WIDTH:0] sum, sh, diff;
  logic last, ge;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == S_MUL || state == S_DIV;
  assign done = state == S_DONE;
  always_comb begin
    state_n = state;
    if (state == S_IDLE)
      state_n = !start ? S_IDLE : op == ALU_MULTU ? S_MUL : op == ALU_DIVU ? S_DIV : S_IDLE;
    else if (state == S_DONE)
      state_n = S_IDLE;
    else if (last)
      state_n = S_DONE;
  end
  // ph/pl hold the running product for MUL and remainder/quotient for DIV;
  // a zero divisor always compares ge, giving all-ones quotient and remainder = dividend
  always_comb begin
    sum  = {1'b0, ph} + {1'b0, pl[0] ? m : '0};
    sh   = {ph, pl[WIDTH-1]};
    diff = sh - {1'b0, m};
    ge   = sh >= {1'b0, m};
    nh   = state == S_MUL ? sum[WIDTH:1] : ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    nl   = state == S_MUL ? {sum[0], pl[WIDTH-1:1]} : {pl[WIDTH-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      m     <= '0;
      ph    <= '0;
      pl    <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && state_n != S_IDLE) begin
        m   <= op == ALU_MULTU ? a : b;
        pl  <= op == ALU_MULTU ? b : a;
        ph  <= '0;
        cnt <= '0;
      end else if (busy) begin
        ph  <= nh;
        pl  <= nl;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          hi <= nh;
          lo <= nl;
        end
      end
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: combinational MIPS ALU with an iterative MULTU/DIVU engine
module alu_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  alu_muldiv_if.slave bus
);
  logic [WIDTH-1:0] a, b, add, sub, res, hi, lo;
  logic busy, done;
  assign a = bus.opA;
  assign b = bus.opB;
  assign add = a + b;
  assign sub = a - b;
  muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk(clk), .reset(reset), .start(bus.start), .op(bus.ALUop),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always_comb begin
    res = '0;
    case (bus.ALUop)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD:  res = add;
      ALU_SUB:  res = sub;
      ALU_SLT:  res = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: res = WIDTH'(a < b);
      ALU_NOR:  res = ~(a | b);
      ALU_MFHI: res = hi;
      ALU_MFLO: res = lo;
      default:  res = '0;
    endcase
  end
  assign bus.result = res;
  assign bus.zero = res == '0;
  assign bus.overflow =
    bus.ALUop == ALU_ADD ? a[WIDTH-1] == b[WIDTH-1] && add[WIDTH-1] != a[WIDTH-1] :
    bus.ALUop == ALU_SUB ? a[WIDTH-1] != b[WIDTH-1] && sub[WIDTH-1] != a[WIDTH-1] : 1'b0;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi = hi;
  assign bus.lo = lo;
endmodule
